serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter DIGIT, default 1, giving the bits added per clock cycle; WIDTH mod DIGIT SHALL be 0.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request a new operation; sampled on the rising clk edge.
REQ-006 in1  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-007 in2  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-008 cIn  input  1  carry-in for add mode; sampled with operands.
REQ-009 sub  input  1  mode select: 0 = add A+B+cIn, 1 = subtract A-B; sampled with operands.
REQ-010 sum  output  WIDTH  registered result of the last completed operation.
REQ-011 cOut  output  1  carry-out of the last completed operation.
REQ-012 overflow  output  1  signed (two's-complement) overflow of the last completed operation.
REQ-013 zero  output  1  1 when the last completed sum equals 0.
REQ-014 busy  output  1  1 while an operation is in progress.
REQ-015 done  output  1  one-cycle pulse marking completion.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE + start=1 SHALL capture in1, in2, cIn and sub, clear the digit counter, enter RUN and set busy=1 on the same edge.
REQ-018 RUN SHALL add one DIGIT-bit slice per cycle, LSB slice first, with the carry registered between slices.
REQ-019 After N = WIDTH/DIGIT RUN cycles the FSM SHALL enter DONE, update sum, cOut, overflow and zero, set busy=0, and set done=1 for exactly one cycle.
REQ-020 Latency SHALL be exactly N cycles from the accepting edge to the edge on which done rises.
REQ-021 DONE SHALL return to IDLE on the next edge; if start=1 in DONE, it SHALL be accepted as in IDLE (back-to-back operation, no bubble).
REQ-022 start while in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-023 In subtract mode, the adder SHALL use ~B and carry-in 1, and cIn SHALL be ignored; cOut=1 means no borrow.
REQ-024 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; the carry SHALL leave only via cOut.
REQ-026 sum, cOut, overflow and zero SHALL hold their values from the previous completion until the next done; partial results SHALL never be visible.
REQ-027 A change on in1, in2, cIn or sub after the accepting edge SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, sum=0, cOut=0, overflow=0, zero=0, busy=0, done=0, and clear the internal operand, carry and counter registers.
REQ-029 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst falls SHALL run normally.

Structure
REQ-030 The FSM state encodings and the default WIDTH/DIGIT values SHALL reside in the shared package adder_pkg.
REQ-031 The per-cycle slice adder SHALL be the sub-module digit_adder (DIGIT-bit ripple of full adders, ports in1, in2, cIn, sum, cOut, plus the MSB carry-in for overflow).
REQ-032 The datapath SHALL use right-shifting operand and result registers, with no WIDTH-wide adder.

Verification
REQ-033 WIDTH=32, DIGIT=1: 0xFFFFFFFF+0x00000001, cIn=0, sub=0 -> done 32 cycles after acceptance; sum=0, cOut=1, zero=1, overflow=0.
REQ-034 0x7FFFFFFF+0x00000001 -> sum=0x80000000, overflow=1, cOut=0, zero=0.
REQ-035 sub=1, 5-7, cIn=1 -> sum=0xFFFFFFFE, cOut=0, overflow=0 (cIn ignored).
REQ-036 Second start with different operands 5 cycles into RUN -> ignored; the result is that of the first operation; a start on the done cycle is accepted, with the next done 32 cycles later.
REQ-037 rst pulse at RUN cycle 10 -> busy=0 and all outputs 0 immediately, no done; then 3+4 -> sum=7 after 32 cycles.
REQ-038 WIDTH=32, DIGIT=8: 0x12345678+0x11111111 -> done 4 cycles after acceptance, sum=0x23456789, cOut=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the digit-serial adder: default geometry and FSM state encodings.
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple of full adders; purely combinational, used once per clock by serial_adder.
// cMsb is the carry into the top bit, so the caller can derive signed overflow.
module digit_adder import adder_pkg::*; #(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] in1,
  input  logic [DIGIT-1:0] in2,
  input  logic             cIn,
  output logic [DIGIT-1:0] sum,
  output logic             cOut,
  output logic             cMsb
);

  always_comb begin
    logic c;
    c    = cIn;
    cMsb = cIn;
    sum  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cMsb = c;
      sum[i] = in1[i] ^ in2[i] ^ c;
      c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
    end
    cOut = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: WIDTH/DIGIT cycles from accepting start to the done pulse.
// start is ignored while busy; a start on the done cycle is taken with no bubble.
module serial_adder import adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cIn,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] acc_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .in1  (a_q[DIGIT-1:0]),
    .in2  (b_q[DIGIT-1:0]),
    .cIn  (carry_q),
    .sum  (slice_sum),
    .cOut (slice_cout),
    .cMsb (slice_cmsb)
  );

  // New slice enters at the top; after N shifts the LSB slice has reached bit 0.
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = acc_shift;
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_cmsb;
          zero_d  = (acc_shift == '0);
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          // Subtraction is A + ~B + 1; the external carry-in is dropped.
          state_d = ST_RUN;
          a_d     = in1;
          b_d     = sub ? ~in2 : in2;
          carry_d = sub ? 1'b1 : cIn;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum      = sum_q;
  assign cOut     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (DIGIT=1 and DIGIT=8) against an arithmetic model.
module tb_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, start, start8, cIn, sub;
  logic [31:0] in1, in2;
  logic [31:0] sum, sum8;
  logic        cOut, overflow, zero, busy, done;
  logic        cOut8, overflow8, zero8, busy8, done8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(32), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .cIn(cIn), .sub(sub),
    .sum(sum), .cOut(cOut), .overflow(overflow), .zero(zero), .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(32), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in1(in1), .in2(in2), .cIn(cIn), .sub(sub),
    .sum(sum8), .cOut(cOut8), .overflow(overflow8), .zero(zero8), .busy(busy8), .done(done8)
  );

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    res_t        r;
    logic [31:0] bx;
    logic [32:0] t;
    bx     = s ? ~b : b;
    t      = {1'b0, a} + {1'b0, bx} + 33'(s ? 1'b1 : c);
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (a[31] == bx[31]) && (t[31] != a[31]);
    r.zero = (t[31:0] == 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    in1 = $urandom;
    in2 = $urandom;
    cIn = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    in1 = a; in2 = b; cIn = c; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".sum"},  64'(sum), 64'(e.sum));
    chk({tag, ".cOut"}, 64'(cOut), 64'(e.cout));
    chk({tag, ".ovf"},  64'(overflow), 64'(e.ovf));
    chk({tag, ".zero"}, 64'(zero), 64'(e.zero));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    res_t e;
    int   cyc;
    e = model(a, b, c, s);
    drive_start(a, b, c, s);
    chk({tag, ".busy_run"}, 64'(busy), 64'd1);
    wait_done(cyc);
    chk({tag, ".latency"}, 64'(cyc), 64'd32);
    check_res(tag, e);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(done), 64'd0);
    chk({tag, ".hold"}, 64'(sum), 64'(e.sum));
  endtask

  task automatic run_op8(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    res_t e;
    int   cyc;
    e = model(a, b, c, s);
    in1 = a; in2 = b; cIn = c; sub = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    scramble();
    cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (done8) begin cyc = i; break; end
    end
    chk({tag, ".latency"}, 64'(cyc), 64'd4);
    chk({tag, ".sum"},  64'(sum8), 64'(e.sum));
    chk({tag, ".cOut"}, 64'(cOut8), 64'(e.cout));
    chk({tag, ".ovf"},  64'(overflow8), 64'(e.ovf));
    chk({tag, ".zero"}, 64'(zero8), 64'(e.zero));
    @(posedge clk); #1;
  endtask

  initial begin
    res_t e1, e3;
    int   cyc;
    logic seen;
    logic [31:0] ra, rb;

    // Reset state
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    in1 = '0; in2 = '0; cIn = 1'b0; sub = 1'b0;
    #2;
    chk("rst.sum", 64'(sum), 64'd0);
    chk("rst.flags", 64'({cOut, overflow, zero, busy, done}), 64'd0);
    chk("rst.flags8", 64'({cOut8, overflow8, zero8, busy8, done8}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("sovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("sub5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    run_op("negovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    run_op("cin",    32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rb = (k % 4 == 3) ? ra : 32'($urandom);
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
    end

    // start mid-RUN ignored; start on the done cycle accepted back-to-back
    e1 = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    drive_start(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    in1 = 32'hDEAD_BEEF; in2 = 32'h0BAD_F00D; cIn = 1'b0; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    chk("ign.latency", 64'(cyc), 64'd27);
    check_res("ign", e1);
    e3 = model(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    drive_start(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    chk("b2b.busy", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("b2b.latency", 64'(cyc), 64'd32);
    check_res("b2b", e3);

    // Reset mid-RUN aborts with no done
    drive_start(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.sum", 64'(sum), 64'd0);
    chk("abort.flags", 64'({cOut, overflow, zero, busy, done}), 64'd0);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done;
    end
    chk("abort.nodone", 64'(seen), 64'd0);
    run_op("post_rst", 32'd3, 32'd4, 1'b0, 1'b0);

    run_op8("d8", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_op8("d8rand", 32'($urandom), 32'($urandom), 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
